qspi_ram_reader: RTL and testbench
==================================

# qspi_ram_reader

Burst read engine for the QSPI PSRAM on the RAM PMOD. It drives the chip-select, clock, bank-select and io0..io3 pins that the top level routes to uio. It accepts a start address, bank and byte count, then issues a quad fast-read (0xEB). It streams the returned bytes to the consumer inside the main design, which is either the SPI screen pixel feeder or the CPU fetch logic.

## Interface
- DUMMY_CYCLES, 6: number of SPI clocks with io released between the address and the data phase.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_start  in  1  request a burst. Accepted only when out_busy=0.
- in_addr  in  24  byte address, latched on accept.
- in_bank  in  2  PMOD bank select, latched on accept.
- in_len  in  8  byte count, latched on accept. 1..255 as given; 0 means 256.
- out_busy  out  1  high from the cycle after accept through the DONE cycle.
- out_data  out  8  returned byte.
- out_data_valid  out  1  one-cycle strobe per byte. There is no backpressure; the consumer must take the byte that cycle.
- out_ram_csn  out  1  PSRAM chip select, active low.
- out_ram_clk  out  1  SPI clock.
- out_ram_bank  out  2  registered bank select.
- inout_ram_ioN_i, inout_ram_ioN_o, inout_ram_ioN_oe (N=0..3)  in/out/out  1 each  split tristate per data line.

## Operation
- States: IDLE, CMD, ADDR, DUMMY, DATA, DONE.
- SPI clock period is 2 system cycles:
  - phase 0: out_ram_clk=0; outputs update.
  - phase 1: out_ram_clk=1.
  - Inputs are sampled on the clock edge that ends phase 1.
- IDLE:
  - csn=1, clk=0, all oe=0, io_o=0.
  - in_start=1 latches addr, bank and len and moves to CMD.
- CMD: 8 SPI clocks.
  - io0 carries 0xEB, MSB first; io0_oe=1.
  - io1..io3 oe=0.
- ADDR: 6 SPI clocks.
  - All oe=1; io[3:0] carries address nibbles, most significant first (addr[23:20] first).
- DUMMY: DUMMY_CYCLES SPI clocks; all oe=0.
- DATA: 2 SPI clocks per byte; all oe=0.
  - First sampled nibble is data[7:4], second is data[3:0].
  - io3 is the nibble MSB.
  - out_data and out_data_valid are registered the cycle after the low nibble is sampled.
  - Byte counter decrements per byte. After the last byte's low nibble is sampled, go to DONE.
- DONE: one cycle with csn=1, clk=0, then IDLE.
  - The last byte's valid strobe coincides with DONE.
- out_ram_bank:
  - Updates on accept and holds after the burst ends.
  - Reset value 0.
- in_start while busy, including during DONE: ignored, no effect.
- reset asserted in any state: the next cycle is IDLE with csn=1, clk=0, all oe=0, valid=0, busy=0 and bank=0. Any partial byte is discarded.
- Address is not wrapped or checked; PSRAM page behaviour is the caller's concern.

## Timing
- Reset values:
  - csn=1, clk=0, bank=0.
  - all io_o=0, all oe=0.
  - busy=0, data=0x00, valid=0.
- Accept at cycle 0 (in_start high while IDLE).
- csn=0 and busy=1 from cycle 1.
- CMD occupies cycles 1..16; ADDR occupies 17..28.
- DUMMY occupies 29..28+2·DUMMY_CYCLES; that is 29..40 for the default.
- First out_data_valid at cycle 29+2·DUMMY_CYCLES+4, i.e. 45 for the default.
- Subsequent bytes follow every 4 cycles.
- DONE is 1 cycle after the last low-nibble sample; busy=0 the cycle after DONE.
- A new burst can be accepted the first cycle busy=0.

## Test plan
- Reset values: assert reset for 2 cycles, then check every output against its reset value. Repeat with reset held for 1 cycle while in DATA; the following cycle must be IDLE with no further valid strobe.
- Single byte: start with addr=0x123456, bank=2, len=1.
  - io0 over 8 SPI clocks must read 0xEB.
  - ADDR nibbles must be 1,2,3,4,5,6 with oe=0xF.
  - Model returns nibbles 0xA then 0x5 → out_data=0xA5 with valid at cycle 45.
  - out_ram_bank=2 from cycle 1 onward.
- Burst of 4, model returning 0x00,0xFF,0x3C,0xC3: expect 4 valid strobes at cycles 45, 49, 53, 57. Then DONE (csn=1) at cycle 57 and busy=0 at 58.
- len=0: exactly 256 valid strobes, with bytes matching an incrementing model pattern.
- in_start pulsed at cycles 5 and 57 of a len=4 burst: both ignored, no restart. A start at cycle 58 is accepted, with csn=0 at 59.
- oe audit across a full burst:
  - io0_oe=1 and io1..3 oe=0 only in CMD.
  - All oe=1 only in ADDR.
  - All oe=0 otherwise.
  - out_ram_clk never toggles while csn=1.

Source files
------------

// File: rtl/qspi_ram_reader_if.sv
// Signal bundle between the QSPI PSRAM burst reader and the rest of the chip.
//
// Burst request side:
//   in_start, in_addr[23:0], in_bank[1:0], in_len[7:0]   request a burst
//   out_busy, out_data[7:0], out_data_valid               engine status and byte stream
// PSRAM pad side:
//   out_ram_csn, out_ram_clk, out_ram_bank[1:0]           chip select, SPI clock, bank
//   inout_ram_ioN_i / _o / _oe (N = 0..3)                 split tristate data lines
//
// The slave modport is the reader's view. The master modport is the view of
// whoever issues requests, consumes bytes and connects the pads.
interface qspi_ram_reader_if;
    logic        in_start;
    logic [23:0] in_addr;
    logic [1:0]  in_bank;
    logic [7:0]  in_len;

    logic        out_busy;
    logic [7:0]  out_data;
    logic        out_data_valid;

    logic        out_ram_csn;
    logic        out_ram_clk;
    logic [1:0]  out_ram_bank;

    logic        inout_ram_io0_i;
    logic        inout_ram_io1_i;
    logic        inout_ram_io2_i;
    logic        inout_ram_io3_i;
    logic        inout_ram_io0_o;
    logic        inout_ram_io1_o;
    logic        inout_ram_io2_o;
    logic        inout_ram_io3_o;
    logic        inout_ram_io0_oe;
    logic        inout_ram_io1_oe;
    logic        inout_ram_io2_oe;
    logic        inout_ram_io3_oe;

    modport slave (
        input  in_start, in_addr, in_bank, in_len,
        output out_busy, out_data, out_data_valid,
        output out_ram_csn, out_ram_clk, out_ram_bank,
        input  inout_ram_io0_i, inout_ram_io1_i, inout_ram_io2_i, inout_ram_io3_i,
        output inout_ram_io0_o, inout_ram_io1_o, inout_ram_io2_o, inout_ram_io3_o,
        output inout_ram_io0_oe, inout_ram_io1_oe, inout_ram_io2_oe, inout_ram_io3_oe
    );

    modport master (
        output in_start, in_addr, in_bank, in_len,
        input  out_busy, out_data, out_data_valid,
        input  out_ram_csn, out_ram_clk, out_ram_bank,
        output inout_ram_io0_i, inout_ram_io1_i, inout_ram_io2_i, inout_ram_io3_i,
        input  inout_ram_io0_o, inout_ram_io1_o, inout_ram_io2_o, inout_ram_io3_o,
        input  inout_ram_io0_oe, inout_ram_io1_oe, inout_ram_io2_oe, inout_ram_io3_oe
    );
endinterface

// File: rtl/qspi_ram_reader.sv
// Burst read engine for the QSPI PSRAM on the RAM PMOD.
//
// Accepts a start address, bank and byte count, issues a quad fast-read (0xEB)
// with the opcode on io0, a 24-bit address on io[3:0], DUMMY_CYCLES released
// clocks, then streams the returned bytes out one strobe per byte.
//
// Ports:
//   clock  system clock; the SPI clock runs at half this rate
//   reset  synchronous, active-high
//   bus    qspi_ram_reader_if.slave: request inputs, byte stream, PSRAM pads
//
// Each SPI clock spans two system cycles: phase 0 with out_ram_clk low (pins
// change), phase 1 with out_ram_clk high. io inputs are captured on the edge
// closing phase 1.
module qspi_ram_reader #(
    parameter int DUMMY_CYCLES = 6   // must be 1..32
) (
    input  logic              clock,
    input  logic              reset,
    qspi_ram_reader_if.slave  bus
);

    localparam logic [7:0] CMD_QUAD_READ = 8'hEB;
    localparam logic [4:0] CMD_LAST      = 5'd7;
    localparam logic [4:0] ADDR_LAST     = 5'd5;
    localparam logic [4:0] DUMMY_LAST    = 5'(DUMMY_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;

    state_t      state_q, state_d;
    logic        phase_q;          // 0: SPI clock low half, 1: high half
    logic [4:0]  clk_cnt_q;        // SPI clocks completed in the current state
    logic [23:0] addr_q;           // shifted left one nibble per ADDR clock
    logic [1:0]  bank_q;
    logic [8:0]  bytes_left_q;     // 9 bits so a length of 0 can mean 256
    logic        low_nibble_q;     // next DATA sample is the low nibble
    logic [3:0]  high_nibble_q;
    logic [7:0]  data_q;
    logic        valid_q;

    logic        csn;
    logic        sclk;
    logic [3:0]  io_in;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic        clk_done;         // this cycle closes the last SPI clock of the state

    assign io_in = {bus.inout_ram_io3_i, bus.inout_ram_io2_i,
                    bus.inout_ram_io1_i, bus.inout_ram_io0_i};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // updates from the values present before the edge.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        csn      = 1'b1;
        sclk     = 1'b0;
        io_out   = 4'h0;
        io_oe    = 4'h0;
        clk_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_start) state_d = CMD;
            end
            CMD: begin
                csn       = 1'b0;
                sclk      = phase_q;
                io_out[0] = CMD_QUAD_READ[3'd7 - clk_cnt_q[2:0]];
                io_oe     = 4'b0001;
                clk_done  = phase_q && (clk_cnt_q == CMD_LAST);
                if (clk_done) state_d = ADDR;
            end
            ADDR: begin
                csn      = 1'b0;
                sclk     = phase_q;
                io_out   = addr_q[23:20];
                io_oe    = 4'b1111;
                clk_done = phase_q && (clk_cnt_q == ADDR_LAST);
                if (clk_done) state_d = DUMMY;
            end
            DUMMY: begin
                csn      = 1'b0;
                sclk     = phase_q;
                clk_done = phase_q && (clk_cnt_q == DUMMY_LAST);
                if (clk_done) state_d = DATA;
            end
            DATA: begin
                csn  = 1'b0;
                sclk = phase_q;
                // Leave only after the low nibble of the final byte is captured.
                if (phase_q && low_nibble_q && (bytes_left_q == 9'd1)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q       <= 1'b0;
            clk_cnt_q     <= 5'd0;
            addr_q        <= 24'h0;
            bank_q        <= 2'd0;
            bytes_left_q  <= 9'd0;
            low_nibble_q  <= 1'b0;
            high_nibble_q <= 4'h0;
            data_q        <= 8'h00;
            valid_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    phase_q      <= 1'b0;
                    clk_cnt_q    <= 5'd0;
                    low_nibble_q <= 1'b0;
                    if (bus.in_start) begin
                        addr_q       <= bus.in_addr;
                        bank_q       <= bus.in_bank;
                        bytes_left_q <= {(bus.in_len == 8'd0), bus.in_len};
                    end
                end
                CMD, ADDR, DUMMY, DATA: begin
                    phase_q <= ~phase_q;
                    if (phase_q) begin
                        clk_cnt_q <= clk_done ? 5'd0 : clk_cnt_q + 5'd1;
                        if (state_q == ADDR) addr_q <= {addr_q[19:0], 4'h0};
                        if (state_q == DATA) begin
                            low_nibble_q <= ~low_nibble_q;
                            if (!low_nibble_q) begin
                                high_nibble_q <= io_in;
                            end else begin
                                data_q       <= {high_nibble_q, io_in};
                                valid_q      <= 1'b1;
                                bytes_left_q <= bytes_left_q - 9'd1;
                            end
                        end
                    end
                end
                default: begin
                    phase_q   <= 1'b0;
                    clk_cnt_q <= 5'd0;
                end
            endcase
        end
    end

    assign bus.out_busy         = (state_q != IDLE);
    assign bus.out_data         = data_q;
    assign bus.out_data_valid   = valid_q;
    assign bus.out_ram_csn      = csn;
    assign bus.out_ram_clk      = sclk;
    assign bus.out_ram_bank     = bank_q;
    assign bus.inout_ram_io0_o  = io_out[0];
    assign bus.inout_ram_io1_o  = io_out[1];
    assign bus.inout_ram_io2_o  = io_out[2];
    assign bus.inout_ram_io3_o  = io_out[3];
    assign bus.inout_ram_io0_oe = io_oe[0];
    assign bus.inout_ram_io1_oe = io_oe[1];
    assign bus.inout_ram_io2_oe = io_oe[2];
    assign bus.inout_ram_io3_oe = io_oe[3];

endmodule

// File: tb/tb_qspi_ram_reader.sv
// Testbench for qspi_ram_reader: a behavioural PSRAM answers with bytes from
// a local memory, a table of bursts is run, then hand-written sequences cover
// reset mid-burst and start requests while busy.
module tb_qspi_ram_reader;

    localparam int DUMMY       = 6;
    localparam int DATA_IDX    = 8 + 6 + DUMMY;          // first data SPI clock
    localparam int FIRST_VALID = 29 + 2 * DUMMY + 4;     // 45

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    qspi_ram_reader_if bus();

    qspi_ram_reader #(.DUMMY_CYCLES(DUMMY)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- cycle counter and PSRAM model ----------------
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0]  mem [256];
    logic [3:0]  io_drv = 4'h0;
    logic [3:0]  oe_vec, io_o_vec, exp_oe;
    logic [7:0]  cmd_cap = 8'h00;
    logic [23:0] addr_cap = 24'h0;
    int          spi_idx = -1;
    int          k;
    int          audit_err = 0;
    int          strobe_cyc[$];
    logic [7:0]  strobe_data[$];

    assign oe_vec   = {bus.inout_ram_io3_oe, bus.inout_ram_io2_oe, bus.inout_ram_io1_oe, bus.inout_ram_io0_oe};
    assign io_o_vec = {bus.inout_ram_io3_o, bus.inout_ram_io2_o, bus.inout_ram_io1_o, bus.inout_ram_io0_o};
    assign bus.inout_ram_io0_i = io_drv[0];
    assign bus.inout_ram_io1_i = io_drv[1];
    assign bus.inout_ram_io2_i = io_drv[2];
    assign bus.inout_ram_io3_i = io_drv[3];

    // Mid-cycle observer: logs strobes, counts SPI clocks, captures opcode and
    // address, audits pin enables and presents read data for the next sample.
    always @(negedge clock) begin
        if (bus.out_data_valid) begin
            strobe_cyc.push_back(cyc);
            strobe_data.push_back(bus.out_data);
        end
        if (bus.out_ram_csn) begin
            spi_idx = -1;
            io_drv  = 4'h0;
            if (bus.out_ram_clk !== 1'b0 || oe_vec !== 4'h0) audit_err++;
        end else begin
            if (!bus.out_ram_clk) spi_idx++;
            if (spi_idx == 0 && !bus.out_ram_clk) begin
                cmd_cap  = 8'h00;
                addr_cap = 24'h0;
            end
            exp_oe = (spi_idx < 8) ? 4'b0001 : (spi_idx < 14) ? 4'b1111 : 4'b0000;
            if (oe_vec !== exp_oe) audit_err++;
            if (bus.out_ram_clk) begin
                if (spi_idx < 8)       cmd_cap  = {cmd_cap[6:0], bus.inout_ram_io0_o};
                else if (spi_idx < 14) addr_cap = {addr_cap[19:0], io_o_vec};
            end
            k = spi_idx - DATA_IDX;
            if (k >= 0) io_drv = k[0] ? mem[8'(k / 2)][3:0] : mem[8'(k / 2)][7:4];
            else        io_drv = 4'h0;
        end
    end

    // ---------------- stimulus helpers ----------------
    int start_cyc = 0;

    // Called at a negedge; drives the request for cycle 0, returns at the
    // negedge of cycle 1 with in_start released.
    task automatic start_burst(input logic [23:0] a, input logic [1:0] b, input logic [7:0] l);
        bus.in_addr  = a;
        bus.in_bank  = b;
        bus.in_len   = l;
        bus.in_start = 1'b1;
        start_cyc    = cyc;
        check("busy_cycle0", bus.out_busy, 1'b0);
        @(negedge clock);
        bus.in_start = 1'b0;
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [1:0]  bank;
        logic [7:0]  len;
        logic [31:0] pattern;   // bytes 0..3, MSB first, when incr=0
        logic        incr;      // byte i = i
        int          n_bytes;
    } vec_t;

    task automatic load_mem(input logic [31:0] pattern, input logic incr);
        for (int i = 0; i < 256; i++)
            mem[i] = incr ? 8'(i) : ((i < 4) ? pattern[31 - 8 * i -: 8] : 8'h00);
    endtask

    task automatic run_vec(input vec_t v);
        int last, base, audit_base, got;
        load_mem(v.pattern, v.incr);
        last       = FIRST_VALID + 4 * (v.n_bytes - 1);
        base       = strobe_cyc.size();
        audit_base = audit_err;
        start_burst(v.addr, v.bank, v.len);
        check("csn_cycle1", bus.out_ram_csn, 1'b0);
        check("busy_cycle1", bus.out_busy, 1'b1);
        check("bank_cycle1", bus.out_ram_bank, v.bank);
        while (cyc - start_cyc < last) @(negedge clock);
        check("done_csn", bus.out_ram_csn, 1'b1);
        check("done_busy", bus.out_busy, 1'b1);
        @(negedge clock);
        check("busy_after_done", bus.out_busy, 1'b0);
        check("bank_hold", bus.out_ram_bank, v.bank);
        check("cmd_opcode", cmd_cap, 8'hEB);
        check("addr_nibbles", addr_cap, v.addr);
        check("oe_audit", audit_err - audit_base, 0);
        got = strobe_cyc.size() - base;
        check("strobe_count", got, v.n_bytes);
        for (int i = 0; i < got && i < v.n_bytes; i++) begin
            check("strobe_cycle", strobe_cyc[base + i] - start_cyc, FIRST_VALID + 4 * i);
            check("strobe_data", strobe_data[base + i], mem[8'(i)]);
        end
    endtask

    vec_t vecs[3];

    initial begin
        int base, second;
        vecs[0] = '{24'h123456, 2'd2, 8'd1, 32'hA500_0000, 1'b0, 1};
        vecs[1] = '{24'h00F0A5, 2'd1, 8'd4, 32'h00FF_3CC3, 1'b0, 4};
        vecs[2] = '{24'hABCDEF, 2'd3, 8'd0, 32'h0000_0000, 1'b1, 256};

        bus.in_start = 1'b0;
        bus.in_addr  = 24'h0;
        bus.in_bank  = 2'd0;
        bus.in_len   = 8'd0;
        load_mem(32'h0, 1'b0);

        // Reset values after two reset cycles.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_csn", bus.out_ram_csn, 1'b1);
        check("rst_clk", bus.out_ram_clk, 1'b0);
        check("rst_bank", bus.out_ram_bank, 2'd0);
        check("rst_io_o", io_o_vec, 4'h0);
        check("rst_oe", oe_vec, 4'h0);
        check("rst_busy", bus.out_busy, 1'b0);
        check("rst_data", bus.out_data, 8'h00);
        check("rst_valid", bus.out_data_valid, 1'b0);
        @(negedge clock);

        // Table of bursts: single byte, burst of 4, len=0 (256 bytes).
        for (int v = 0; v < 3; v++) begin
            run_vec(vecs[v]);
            repeat (2) @(negedge clock);
        end

        // Reset held for one cycle while in DATA.
        load_mem(32'h00FF_3CC3, 1'b0);
        start_burst(24'h000100, 2'd3, 8'd4);
        while (cyc - start_cyc < 46) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_csn", bus.out_ram_csn, 1'b1);
        check("mid_rst_clk", bus.out_ram_clk, 1'b0);
        check("mid_rst_oe", oe_vec, 4'h0);
        check("mid_rst_valid", bus.out_data_valid, 1'b0);
        check("mid_rst_busy", bus.out_busy, 1'b0);
        check("mid_rst_bank", bus.out_ram_bank, 2'd0);
        base = strobe_cyc.size();
        repeat (20) @(negedge clock);
        check("mid_rst_no_strobe", strobe_cyc.size() - base, 0);
        check("mid_rst_idle", bus.out_busy, 1'b0);

        // Start pulses at cycles 5 and 57 are ignored; start at 58 is accepted.
        base = strobe_cyc.size();
        start_burst(24'h000200, 2'd1, 8'd4);
        while (cyc - start_cyc < 5) @(negedge clock);
        bus.in_bank  = 2'd3;
        bus.in_len   = 8'd1;
        bus.in_start = 1'b1;
        @(negedge clock);
        bus.in_start = 1'b0;
        while (cyc - start_cyc < 57) @(negedge clock);
        bus.in_start = 1'b1;
        check("ign_bank_c57", bus.out_ram_bank, 2'd1);
        @(negedge clock);
        check("ign_busy_c58", bus.out_busy, 1'b0);
        check("ign_bank_c58", bus.out_ram_bank, 2'd1);
        check("ign_strobes", strobe_cyc.size() - base, 4);
        if (strobe_cyc.size() - base == 4)
            check("ign_last_strobe", strobe_cyc[base + 3] - start_cyc, 57);
        bus.in_bank = 2'd2;
        second = cyc;
        @(negedge clock);
        bus.in_start = 1'b0;
        check("restart_csn_c59", bus.out_ram_csn, 1'b0);
        check("restart_busy_c59", bus.out_busy, 1'b1);
        check("restart_bank_c59", bus.out_ram_bank, 2'd2);
        while (cyc - second < FIRST_VALID + 1) @(negedge clock);
        check("restart_done", bus.out_busy, 1'b0);
        check("restart_strobes", strobe_cyc.size() - base, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
